spi_slave_rx: RTL and testbench

Receive-side endpoint for the 12-bit SPI link. It samples `sclk`, `cs` and `mosi` driven by the link's transmitter, resynchronises them into the local `clk` domain, and reassembles each LSB-first frame into a parallel word. Completed words are presented on a valid/ready port to downstream logic. Short frames, long frames and frames arriving while the previous word is unconsumed are reported as error pulses.

---
 rtl/spi_slave_rx.sv | 106 ++++++++++
 tb/tb_spi_slave_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: resynchronises an LSB-first SPI frame into clk and presents it
// on a valid/ready port, flagging wrong-length frames and overruns.
module spi_slave_rx #(
  parameter int DW          = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_EDGES  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs,
  input  logic          mosi,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          frame_err,
  output logic          overrun
);
  localparam int CMAX = (DW > LEAD_EDGES) ? DW : LEAD_EDGES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_t;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_cs_s, r_mosi_s;
  logic                   r_sclk_d, r_cs_d, r_sample, r_cs_fall, r_cs_rise, r_bit, r_long;
  logic [CW-1:0]          r_cnt;
  logic [DW-1:0]          r_shift;
  state_t                 r_state, w_state_nx;
  logic                   w_restart, w_commit, w_err, w_ovr, w_good, w_free;
  // Edge events are registered so the core acts on them one cycle after detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s  <= '0;
      r_cs_s    <= '1;
      r_mosi_s  <= '0;
      r_sclk_d  <= 1'b0;
      r_cs_d    <= 1'b1;
      r_sample  <= 1'b0;
      r_cs_fall <= 1'b0;
      r_cs_rise <= 1'b0;
      r_bit     <= 1'b0;
    end else begin
      r_sclk_s  <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_cs_s    <= {r_cs_s[SYNC_STAGES-2:0], cs};
      r_mosi_s  <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_sclk_d  <= r_sclk_s[SYNC_STAGES-1];
      r_cs_d    <= r_cs_s[SYNC_STAGES-1];
      r_sample  <= r_sclk_d & ~r_sclk_s[SYNC_STAGES-1];
      r_cs_fall <= r_cs_d & ~r_cs_s[SYNC_STAGES-1];
      r_cs_rise <= ~r_cs_d & r_cs_s[SYNC_STAGES-1];
      r_bit     <= r_mosi_s[SYNC_STAGES-1];
    end
  end
  assign w_free = !dout_valid || dout_ready;
  assign w_good = (r_state == DONE) && !r_long;
  always_comb begin
    w_state_nx = r_state;
    w_restart  = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    w_ovr      = 1'b0;
    if (r_state == IDLE) w_restart = r_cs_fall;
    else if (r_cs_rise) begin
      w_state_nx = IDLE;
      w_commit   = w_good && w_free;
      w_ovr      = w_good && !w_free;
      w_err      = !w_good;
    end
    else if (r_cs_fall) w_restart = 1'b1;
    else if (r_sample && r_state == LEAD && r_cnt == CW'(LEAD_EDGES - 1)) w_state_nx = SHIFT;
    else if (r_sample && r_state == SHIFT && r_cnt == CW'(DW - 1)) w_state_nx = DONE;
    if (w_restart) w_state_nx = (LEAD_EDGES > 0) ? LEAD : SHIFT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end
  // Right-shifting puts the first sampled bit at bit 0 once DW bits are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_long     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= w_err;
      overrun   <= w_ovr;
      if (w_commit) begin
        dout       <= r_shift;
        dout_valid <= 1'b1;
      end else if (dout_ready) dout_valid <= 1'b0;
      if (w_restart) begin
        r_cnt  <= '0;
        r_long <= 1'b0;
      end else if (r_sample) begin
        if (r_state == LEAD) r_cnt <= (w_state_nx == SHIFT) ? '0 : r_cnt + 1'b1;
        if (r_state == SHIFT) begin
          r_shift <= {r_bit, r_shift[DW-1:1]};
          r_cnt   <= r_cnt + 1'b1;
        end
        if (r_state == DONE) r_long <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed SPI frames against spi_slave_rx with a scoreboard
// of expected words matched to valid/ready handshakes.
module tb_spi_slave_rx;
  localparam int DW = 12;
  localparam int HP = 51;
  logic          clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0, dout_ready = 1'b1;
  logic [DW-1:0] dout;
  logic          dout_valid, frame_err, overrun;
  logic [DW-1:0] exp_q[$], obs_q[$];
  int            checks = 0, errors = 0, n_ferr = 0, n_ovr = 0, lat = 0, vcnt = 0;

  spi_slave_rx #(.DW(DW), .SYNC_STAGES(2), .LEAD_EDGES(1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) obs_q.push_back(dout);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_drain(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // pulse=1 raises dout_ready only for the cycle in which the commit lands
  task automatic send_frame(input logic [15:0] d, input int nb, input bit pulse);
    sclk = 1'b1; cs = 1'b0;
    tick(HP);
    sclk = 1'b0;
    tick(HP);
    for (int i = 0; i < nb; i++) begin
      sclk = 1'b1; mosi = d[i];
      tick(HP);
      sclk = 1'b0;
      tick(HP);
    end
    sclk = 1'b1; cs = 1'b1;
    lat = 0; vcnt = 0;
    for (int k = 1; k <= HP; k++) begin
      tick(1);
      if (pulse && k == 3) dout_ready = 1'b1;
      if (pulse && k == 4) dout_ready = 1'b0;
      if (dout_valid) begin
        vcnt++;
        if (lat == 0) lat = k;
      end
    end
    sclk = 1'b0;
    tick(HP);
  endtask

  initial begin
    tick(3);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b1;
    tick(5);

    exp_q.push_back(12'hA5C);
    send_frame(16'h0A5C, 12, 1'b0);
    chk("t1_latency", lat, 4);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_dout", dout, 12'hA5C);
    sb_drain("t1_sb");
    chk("t1_ferr", n_ferr, 0);
    chk("t1_ovr", n_ovr, 0);

    dout_ready = 1'b0;
    exp_q.push_back(12'h001);
    send_frame(16'h0001, 12, 1'b0);
    chk("t2_valid", dout_valid, 1);
    chk("t2_dout", dout, 12'h001);
    send_frame(16'h0FFF, 12, 1'b0);
    chk("t2_ovr", n_ovr, 1);
    chk("t2_dout_kept", dout, 12'h001);
    dout_ready = 1'b1;
    tick(2);
    sb_drain("t2_sb");
    chk("t2_dout_after", dout, 12'h001);
    chk("t2_valid_clr", dout_valid, 0);
    chk("t2_ferr", n_ferr, 0);

    send_frame(16'h0055, 7, 1'b0);
    chk("t3_ferr", n_ferr, 1);
    chk("t3_no_valid", vcnt, 0);
    chk("t3_dout", dout, 12'h001);
    exp_q.push_back(12'h3C3);
    send_frame(16'h03C3, 12, 1'b0);
    sb_drain("t3_sb");
    chk("t3_dout_good", dout, 12'h3C3);

    send_frame(16'h1ABC, 13, 1'b0);
    chk("t4_ferr", n_ferr, 2);
    chk("t4_no_valid", vcnt, 0);
    chk("t4_dout", dout, 12'h3C3);

    dout_ready = 1'b0;
    exp_q.push_back(12'h5A6);
    send_frame(16'h05A6, 12, 1'b0);
    chk("t5_first", dout, 12'h5A6);
    exp_q.push_back(12'h69A);
    send_frame(16'h069A, 12, 1'b1);
    chk("t5_dout", dout, 12'h69A);
    chk("t5_valid", dout_valid, 1);
    chk("t5_ovr", n_ovr, 1);
    dout_ready = 1'b1;
    tick(2);
    sb_drain("t5_sb");

    dout_ready = 1'b0;
    send_frame(16'h0123, 12, 1'b0);
    chk("t6_pre", dout, 12'h123);
    sclk = 1'b1; cs = 1'b0;
    tick(HP);
    sclk = 1'b0;
    tick(HP);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; mosi = i[0];
      tick(HP);
      sclk = 1'b0;
      tick(HP);
    end
    rst = 1'b0;
    tick(1);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_ferr", frame_err, 0);
    chk("t6_rst_ovr", overrun, 0);
    cs = 1'b1; mosi = 1'b0;
    tick(5);
    rst = 1'b1;
    dout_ready = 1'b1;
    tick(5);
    obs_q.delete();
    exp_q.push_back(12'h800);
    send_frame(16'h0800, 12, 1'b0);
    sb_drain("t6_sb");
    chk("t6_dout", dout, 12'h800);
    chk("t6_ferr", n_ferr, 2);
    chk("t6_ovr", n_ovr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
